rc4_prga_decryptor: RTL and testbench
=====================================

Name: rc4_prga_decryptor

Overview:
- RC4 keystream generation (PRGA) and XOR decrypt stage of the breaker datapath.
- Runs after the key-schedule stage has left a permuted S array in the shared 256x8 S-RAM.
- Reads the encrypted message from the 32x8 ciphertext ROM and produces the decrypted byte array plus done.
- Its outputs feed the downstream decrypted-data writer and the key-search controller, via key_bad for early rejection.

Parameters:
- MSG_LEN, 32, number of message bytes; ROM depth.
- EARLY_ABORT, 1, when 1, stop at the first byte outside {0x61..0x7A, 0x20}.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  begin decrypt; sampled in IDLE or DONE
- s_addr  out  8  S-RAM address
- s_wdata  out  8  S-RAM write data
- s_wren  out  1  S-RAM write enable
- s_rdata  in  8  S-RAM read data
- rom_addr  out  5  ciphertext ROM address, log2(MSG_LEN)
- rom_rdata  in  8  ciphertext ROM data
- decrypted_data  out  8 x MSG_LEN  unpacked byte array, index k = message byte k
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high while in DONE
- key_bad  out  1  valid when done=1; 1 means the abort condition fired

Behaviour:
- Reset: state=IDLE; i=j=k=0; si=sj=0; all decrypted_data=0; s_wren=0; done=0; busy=0; key_bad=0.
- Reset mid-operation has the same effect. Any in-flight write is dropped in the same cycle.
- States: IDLE, INC, RD_SI, WT_SI, CAP_SI, RD_SJ, WT_SJ, CAP_SJ, WR_I, WR_J, RD_F, WT_F, CAP_F, DONE.
- IDLE/DONE + start=1: clear i, j, k, key_bad and decrypted_data, then go to INC. Without start, hold.
- INC: i <= i+1, 8-bit wrap.
- RD_SI / WT_SI: s_addr=i. CAP_SI: si <= s_rdata; j <= j+s_rdata, mod 256.
- RD_SJ / WT_SJ: s_addr=j. CAP_SJ: sj <= s_rdata.
- WR_I: s_addr=i, s_wdata=sj, s_wren=1.
- WR_J: s_addr=j, s_wdata=si, s_wren=1.
- RD_F / WT_F: s_addr=(si+sj) mod 256; rom_addr=k.
- CAP_F: decrypted_data[k] <= s_rdata ^ rom_rdata.
  - If EARLY_ABORT and the byte is not in 0x61..0x7A and not 0x20: key_bad <= 1, go to DONE.
  - Else if k==MSG_LEN-1: go to DONE.
  - Else k <= k+1, go to INC.
- Read timing: address held constant across the RD, WT and CAP states. s_rdata and rom_rdata are sampled only in CAP states. This is valid for RAM/ROM with registered address and either registered or unregistered q.
- s_wren is high only in WR_I and WR_J. s_addr is 0 in IDLE and DONE.
- i==j is legal: WR_J overwrites WR_I with the same value, leaving S unchanged.
- Latency, no abort: start sampled at cycle 0; byte k written at the end of cycle 12(k+1); done=1 from cycle 12*MSG_LEN+1 (385 for 32).
- DONE is sticky until reset or start. decrypted_data holds its values.
- With an abort, bytes after the failing index stay 0.
- The S array is left modified. Re-running KSA before the next start is the controller's responsibility.

Decomposition:
- Package rc4_pkg holds:
  - state enum;
  - MSG_LEN default;
  - CHAR_LO=8'h61, CHAR_HI=8'h7A, CHAR_SP=8'h20;
  - function is_valid_char(byte).
- Sub-module rc4_char_check: combinational validity check, shared with other stages.
- The FSM and datapath stay in one module.

Test Plan:
- Identity S (S[x]=x), ROM = 63,64,66,... (keystream 02,05,07,...), EARLY_ABORT=0, start pulse.
  - decrypted_data[0..2] = 61,61,61; done rises at cycle 385.
  - S[2]=03, S[3]=05, S[5]=02 after step 3.
- Same setup, ROM[1]=0x00, EARLY_ABORT=1.
  - decrypted_data[1]=05, key_bad=1, done at cycle 25.
  - decrypted_data[2..31]=0.
- KSA("Key") S image in RAM, ROM = BB F3 16 E8 D9 40 AF 0A D3, rest 00, EARLY_ABORT=0.
  - decrypted_data[0..8] = "Plaintext".
- Reset asserted at cycle 100 of a run.
  - Next cycle: IDLE, done=0, s_wren=0, all outputs 0.
  - A new start then produces the full identity-S result again, with the RAM re-initialised.
- start held high through DONE.
  - Restart occurs; done drops for one full run.
  - Protocol checks: s_wren high only in WR_I/WR_J, never two consecutive writes to the same address with differing data except when i==j.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 PRGA / decrypt stage.
package rc4_pkg;

    localparam int unsigned MSG_LEN_DEF = 32;

    localparam logic [7:0] CHAR_LO = 8'h61;
    localparam logic [7:0] CHAR_HI = 8'h7A;
    localparam logic [7:0] CHAR_SP = 8'h20;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INC,
        ST_RD_SI,
        ST_WT_SI,
        ST_CAP_SI,
        ST_RD_SJ,
        ST_WT_SJ,
        ST_CAP_SJ,
        ST_WR_I,
        ST_WR_J,
        ST_RD_F,
        ST_WT_F,
        ST_CAP_F,
        ST_DONE
    } rc4_state_e;

    // Plaintext alphabet accepted by the key search: lowercase letters and space.
    function automatic logic is_valid_char(input logic [7:0] b);
        return ((b >= CHAR_LO) && (b <= CHAR_HI)) || (b == CHAR_SP);
    endfunction

endpackage

// File: rtl/rc4_char_check.sv
// Combinational plaintext-alphabet check, shared with other breaker stages.
module rc4_char_check
    import rc4_pkg::*;
(
    input  logic [7:0] data,
    output logic       valid_c
);

    assign valid_c = is_valid_char(data);

endmodule

// File: rtl/rc4_prga_decryptor.sv
// RC4 keystream generation over a shared S-RAM, XORed with the ciphertext ROM.
module rc4_prga_decryptor
    import rc4_pkg::*;
#(
    parameter int unsigned MSG_LEN     = MSG_LEN_DEF,
    parameter bit          EARLY_ABORT = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    output logic [7:0]                 s_addr,
    output logic [7:0]                 s_wdata,
    output logic                       s_wren,
    input  logic [7:0]                 s_rdata,
    output logic [$clog2(MSG_LEN)-1:0] rom_addr,
    input  logic [7:0]                 rom_rdata,
    output logic [7:0]                 decrypted_data [MSG_LEN],
    output logic                       busy,
    output logic                       done,
    output logic                       key_bad
);

    localparam int unsigned AW = $clog2(MSG_LEN);

    rc4_state_e     state;
    logic [7:0]     i;
    logic [7:0]     j;
    logic [7:0]     si;
    logic [7:0]     sj;
    logic [AW-1:0]  k;
    logic           wren_q;
    logic [7:0]     plain_c;
    logic           plain_ok_c;

    assign plain_c = s_rdata ^ rom_rdata;

    rc4_char_check u_char_check (
        .data    (plain_c),
        .valid_c (plain_ok_c)
    );

    // Write strobe is gated by reset so a write in flight is dropped at once.
    assign s_wren = wren_q & ~reset;

    // Addresses are registered one state ahead so they are stable for RD, WT and CAP.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            i        <= '0;
            j        <= '0;
            k        <= '0;
            si       <= '0;
            sj       <= '0;
            s_addr   <= '0;
            s_wdata  <= '0;
            wren_q   <= 1'b0;
            rom_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            key_bad  <= 1'b0;
            for (int unsigned n = 0; n < MSG_LEN; n++) begin
                decrypted_data[n] <= '0;
            end
        end else begin
            wren_q <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        i        <= '0;
                        j        <= '0;
                        k        <= '0;
                        key_bad  <= 1'b0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        s_addr   <= '0;
                        for (int unsigned n = 0; n < MSG_LEN; n++) begin
                            decrypted_data[n] <= '0;
                        end
                        state    <= ST_INC;
                    end
                end
                ST_INC: begin
                    i      <= i + 8'd1;
                    s_addr <= i + 8'd1;
                    state  <= ST_RD_SI;
                end
                ST_RD_SI: state <= ST_WT_SI;
                ST_WT_SI: state <= ST_CAP_SI;
                ST_CAP_SI: begin
                    si     <= s_rdata;
                    j      <= j + s_rdata;
                    s_addr <= j + s_rdata;
                    state  <= ST_RD_SJ;
                end
                ST_RD_SJ: state <= ST_WT_SJ;
                ST_WT_SJ: state <= ST_CAP_SJ;
                ST_CAP_SJ: begin
                    sj      <= s_rdata;
                    s_addr  <= i;
                    s_wdata <= s_rdata;
                    wren_q  <= 1'b1;
                    state   <= ST_WR_I;
                end
                ST_WR_I: begin
                    s_addr  <= j;
                    s_wdata <= si;
                    wren_q  <= 1'b1;
                    state   <= ST_WR_J;
                end
                ST_WR_J: begin
                    s_addr   <= si + sj;
                    rom_addr <= k;
                    state    <= ST_RD_F;
                end
                ST_RD_F: state <= ST_WT_F;
                ST_WT_F: state <= ST_CAP_F;
                ST_CAP_F: begin
                    decrypted_data[k] <= plain_c;
                    s_addr            <= '0;
                    if (EARLY_ABORT && !plain_ok_c) begin
                        key_bad <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= ST_DONE;
                    end else if (k == AW'(MSG_LEN - 1)) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        k       <= k + AW'(1);
                        state   <= ST_INC;
                    end
                end
                default: begin
                    busy   <= 1'b0;
                    done   <= 1'b0;
                    s_addr <= '0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_prga_decryptor.sv
// Scoreboard bench: two decryptors (abort off / on) with behavioural S-RAM and ROM.
module tb_rc4_prga_decryptor;

    localparam int unsigned N = 32;

    typedef logic [7:0] sarr_t [256];
    typedef logic [7:0] marr_t [N];
    typedef struct {
        int         dut;
        int         idx;
        logic [7:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       start     [2];
    logic [7:0] s_addr    [2];
    logic [7:0] s_wdata   [2];
    logic       s_wren    [2];
    logic [7:0] s_rdata   [2];
    logic [4:0] rom_addr  [2];
    logic [7:0] rom_rdata [2];
    logic       busy      [2];
    logic       done      [2];
    logic       key_bad   [2];
    logic [7:0] dd0 [N];
    logic [7:0] dd1 [N];

    sarr_t ram      [2];
    sarr_t ram_img  [2];
    bit    ram_load [2];
    marr_t rom      [2];

    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    rc4_prga_decryptor #(.MSG_LEN(N), .EARLY_ABORT(1'b0)) dut_na (
        .clk(clk), .reset(reset), .start(start[0]),
        .s_addr(s_addr[0]), .s_wdata(s_wdata[0]), .s_wren(s_wren[0]), .s_rdata(s_rdata[0]),
        .rom_addr(rom_addr[0]), .rom_rdata(rom_rdata[0]), .decrypted_data(dd0),
        .busy(busy[0]), .done(done[0]), .key_bad(key_bad[0])
    );

    rc4_prga_decryptor #(.MSG_LEN(N), .EARLY_ABORT(1'b1)) dut_ea (
        .clk(clk), .reset(reset), .start(start[1]),
        .s_addr(s_addr[1]), .s_wdata(s_wdata[1]), .s_wren(s_wren[1]), .s_rdata(s_rdata[1]),
        .rom_addr(rom_addr[1]), .rom_rdata(rom_rdata[1]), .decrypted_data(dd1),
        .busy(busy[1]), .done(done[1]), .key_bad(key_bad[1])
    );

    // Registered-address, registered-q memories.
    always_ff @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (ram_load[g]) ram[g] <= ram_img[g];
            else if (s_wren[g]) ram[g][s_addr[g]] <= s_wdata[g];
            s_rdata[g]   <= ram[g][s_addr[g]];
            rom_rdata[g] <= rom[g][rom_addr[g]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write protocol: bursts of at most two, only while busy, same-address pairs agree.
    logic [7:0] pa [2];
    logic [7:0] pd [2];
    bit         pw [2];
    int         wrun [2] = '{0, 0};
    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            if (reset) check("wren_in_reset", 32'(s_wren[d]), 0);
            if (s_wren[d]) begin
                wrun[d]++;
                check("wr_burst_len", 32'(wrun[d] <= 2), 1);
                check("wr_while_busy", 32'(busy[d]), 1);
                if (pw[d] && s_addr[d] == pa[d]) check("wr_same_addr_data", 32'(s_wdata[d]), 32'(pd[d]));
            end else begin
                wrun[d] = 0;
            end
            pw[d] = s_wren[d];
            pa[d] = s_addr[d];
            pd[d] = s_wdata[d];
        end
    end

    function automatic bit tb_valid(input logic [7:0] b);
        return (b == 8'h20) || (b >= 8'h61 && b <= 8'h7a);
    endfunction

    function automatic sarr_t ident();
        sarr_t s;
        for (int n = 0; n < 256; n++) s[n] = 8'(n);
        return s;
    endfunction

    function automatic sarr_t ksa_key();
        sarr_t      s;
        logic [7:0] key [3];
        logic [7:0] jj;
        logic [7:0] t;
        key = '{8'h4b, 8'h65, 8'h79};
        for (int n = 0; n < 256; n++) s[n] = 8'(n);
        jj = 8'h00;
        for (int n = 0; n < 256; n++) begin
            jj = jj + s[n] + key[n % 3];
            t = s[n]; s[n] = s[jj]; s[jj] = t;
        end
        return s;
    endfunction

    // Reference RC4 PRGA + decrypt.
    task automatic rc4_model(input sarr_t s_in, input marr_t ct, input bit ea,
                             output marr_t pt, output bit bad, output sarr_t s_out);
        sarr_t      s;
        logic [7:0] ii;
        logic [7:0] jj;
        logic [7:0] t;
        logic [7:0] idx;
        s  = s_in;
        ii = 8'h00;
        jj = 8'h00;
        bad = 1'b0;
        for (int n = 0; n < N; n++) pt[n] = 8'h00;
        for (int n = 0; n < N; n++) begin
            ii = ii + 8'h01;
            jj = jj + s[ii];
            t = s[ii]; s[ii] = s[jj]; s[jj] = t;
            idx = s[ii] + s[jj];
            pt[n] = s[idx] ^ ct[n];
            if (ea && !tb_valid(pt[n])) begin
                bad = 1'b1;
                break;
            end
        end
        s_out = s;
    endtask

    task automatic load(input int d, input sarr_t img, input marr_t ct);
        ram_img[d] = img;
        rom[d]     = ct;
        @(negedge clk);
        ram_load[d] = 1'b1;
        @(negedge clk);
        ram_load[d] = 1'b0;
    endtask

    task automatic push(input int d, input int idx, input logic [7:0] val);
        exp_t e;
        e.dut = d; e.idx = idx; e.val = val;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t       e;
        logic [7:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = (e.dut == 0) ? dd0[e.idx] : dd1[e.idx];
            check($sformatf("dut%0d_byte%0d", e.dut, e.idx), 32'(obs), 32'(e.val));
        end
    endtask

    // Start (pulsed or held) and count cycles until done; cycle 0 is the start-sampling cycle.
    task automatic run(input int d, input int reset_at, input int chk_at, input bit hold,
                       output int dcyc);
        int cyc;
        @(negedge clk);
        start[d] = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start[d] = 1'b0;
        cyc  = 1;
        dcyc = -1;
        while (cyc < 2000) begin
            if (done[d]) begin
                dcyc = cyc;
                break;
            end
            if (cyc == chk_at) begin
                check("s2_after_step3", 32'(ram[d][2]), 32'h03);
                check("s3_after_step3", 32'(ram[d][3]), 32'h05);
                check("s5_after_step3", 32'(ram[d][5]), 32'h02);
            end
            if (cyc == reset_at) begin
                reset = 1'b1;
                @(posedge clk);
                #1;
                reset = 1'b0;
                dcyc = 0;
                return;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        if (dcyc < 0) check("done_timeout", 32'(done[d]), 1);
    endtask

    initial begin
        sarr_t      s_fin;
        marr_t      ct;
        marr_t      ks;
        marr_t      pt;
        marr_t      zero;
        bit         bad;
        int         dc;
        string      ptxt;
        logic [7:0] ct_key [9];

        reset = 1'b1;
        start[0] = 1'b0;
        start[1] = 1'b0;
        for (int n = 0; n < N; n++) zero[n] = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_busy", 32'(busy[d]), 0);
            check("rst_done", 32'(done[d]), 0);
            check("rst_key_bad", 32'(key_bad[d]), 0);
            check("rst_s_addr", 32'(s_addr[d]), 0);
        end

        // Identity S, all-'a' message, no abort.
        rc4_model(ident(), zero, 1'b0, ks, bad, s_fin);
        for (int n = 0; n < N; n++) ct[n] = ks[n] ^ 8'h61;
        load(0, ident(), ct);
        for (int n = 0; n < N; n++) push(0, n, 8'h61);
        run(0, -1, 37, 1'b0, dc);
        check("ident_done_cycle", 32'(dc), 385);
        check("ident_key_bad", 32'(key_bad[0]), 0);
        check("ident_busy_in_done", 32'(busy[0]), 0);
        check("ident_s_addr_in_done", 32'(s_addr[0]), 0);
        drain();
        for (int n = 0; n < 256; n++) check($sformatf("ident_final_s%0d", n), 32'(ram[0][n]), 32'(s_fin[n]));

        // Same stream, second byte corrupted, abort enabled.
        ct[1] = 8'h00;
        load(1, ident(), ct);
        push(1, 0, 8'h61);
        push(1, 1, 8'h05);
        for (int n = 2; n < N; n++) push(1, n, 8'h00);
        run(1, -1, -1, 1'b0, dc);
        check("abort_done_cycle", 32'(dc), 25);
        check("abort_key_bad", 32'(key_bad[1]), 1);
        drain();

        // KSA("Key") image decrypting "Plaintext".
        ct_key = '{8'hbb, 8'hf3, 8'h16, 8'he8, 8'hd9, 8'h40, 8'haf, 8'h0a, 8'hd3};
        for (int n = 0; n < N; n++) ct[n] = (n < 9) ? ct_key[n] : 8'h00;
        rc4_model(ksa_key(), ct, 1'b0, pt, bad, s_fin);
        load(0, ksa_key(), ct);
        ptxt = "Plaintext";
        for (int n = 0; n < 9; n++) push(0, n, ptxt[n]);
        for (int n = 9; n < N; n++) push(0, n, pt[n]);
        run(0, -1, -1, 1'b0, dc);
        check("key_done_cycle", 32'(dc), 385);
        drain();

        // Reset in the middle of a run, then a clean rerun.
        for (int n = 0; n < N; n++) ct[n] = ks[n] ^ 8'h61;
        load(0, ident(), ct);
        run(0, 100, -1, 1'b0, dc);
        check("mid_rst_busy", 32'(busy[0]), 0);
        check("mid_rst_done", 32'(done[0]), 0);
        check("mid_rst_wren", 32'(s_wren[0]), 0);
        check("mid_rst_s_addr", 32'(s_addr[0]), 0);
        check("mid_rst_rom_addr", 32'(rom_addr[0]), 0);
        check("mid_rst_key_bad", 32'(key_bad[0]), 0);
        for (int n = 0; n < N; n++) check($sformatf("mid_rst_byte%0d", n), 32'(dd0[n]), 0);
        load(0, ident(), ct);
        for (int n = 0; n < N; n++) push(0, n, 8'h61);
        run(0, -1, 37, 1'b0, dc);
        check("rerun_done_cycle", 32'(dc), 385);
        drain();

        // Start held high through DONE restarts immediately.
        load(0, ident(), ct);
        run(0, -1, -1, 1'b1, dc);
        check("hold_first_done_cycle", 32'(dc), 385);
        @(posedge clk);
        #1;
        check("hold_done_drops", 32'(done[0]), 0);
        check("hold_busy_again", 32'(busy[0]), 1);
        dc = 1;
        while (!done[0] && dc < 2000) begin
            @(posedge clk);
            #1;
            dc++;
        end
        check("hold_second_done_cycle", 32'(dc), 385);
        @(negedge clk);
        start[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("done_sticky", 32'(done[0]), 1);
        check("sticky_busy", 32'(busy[0]), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
